// File: rtl/fir_multichannel_engine.sv
// Multichannel FIR engine: CHANNELS sample streams share one multiply-accumulate unit,
// each channel with its own delay line and BANKS x TAPS coefficient store.
module fir_multichannel_engine #(
    parameter int CHANNELS = 3,
    parameter int TAPS     = 16,
    parameter int DATA_W   = 16,
    parameter int COEFF_W  = 16,
    parameter int BANKS    = 4
) (
    input  logic                               sys_clk,
    input  logic                               rst_n,
    input  logic                               sample_valid,
    input  logic [CHANNELS*DATA_W-1:0]         sample_in,
    input  logic [CHANNELS*$clog2(BANKS)-1:0]  bank_sel,
    output logic                               busy,
    output logic                               out_valid,
    output logic [CHANNELS*DATA_W-1:0]         filter_data,
    output logic [CHANNELS-1:0]                sat_flag,
    output logic                               overrun,
    input  logic                               update_en,
    input  logic [$clog2(CHANNELS):0]          update_channel,
    input  logic [$clog2(BANKS)-1:0]           update_bank,
    input  logic [$clog2(TAPS)-1:0]            update_index,
    input  logic [COEFF_W-1:0]                 update_value
);

    localparam int BANK_W = $clog2(BANKS);
    localparam int TAP_W  = $clog2(TAPS);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int UCH_W  = $clog2(CHANNELS) + 1;
    localparam int PROD_W = DATA_W + COEFF_W + 1;
    localparam int ACC_W  = PROD_W + TAP_W;

    localparam logic signed [ACC_W-1:0] RES_MAX = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] RES_MIN = ~RES_MAX;
    localparam logic [COEFF_W-1:0]      AVG_COEFF = COEFF_W'(1) << (COEFF_W - TAP_W);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MAC, ST_DONE} state_t;

    function automatic logic [COEFF_W-1:0] coeff_reset(input int bank, input int tap);
        if (bank == 0) return (tap == 0) ? '1 : '0;
        if (bank == 1) return AVG_COEFF;
        return '0;
    endfunction

    state_t                     state_q, state_d;
    logic                       busy_q, busy_d;
    logic                       out_valid_q, out_valid_d;
    logic                       overrun_q, overrun_d;
    logic [CHANNELS*DATA_W-1:0] filter_data_q, filter_data_d;
    logic [CHANNELS-1:0]        sat_flag_q, sat_flag_d;
    logic [CHANNELS*DATA_W-1:0] sample_q, sample_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic [TAP_W-1:0]           tap_q, tap_d;
    logic [BANK_W-1:0]          bank_lat_q [CHANNELS];
    logic [BANK_W-1:0]          bank_lat_d [CHANNELS];
    logic [DATA_W-1:0]          shadow_q [CHANNELS];
    logic [DATA_W-1:0]          shadow_d [CHANNELS];
    logic [CHANNELS-1:0]        shadow_sat_q, shadow_sat_d;
    logic signed [DATA_W-1:0]   delay_q [CHANNELS][TAPS];
    logic signed [DATA_W-1:0]   delay_d [CHANNELS][TAPS];
    logic [COEFF_W-1:0]         coeff_q [CHANNELS][BANKS][TAPS];
    logic [COEFF_W-1:0]         coeff_d [CHANNELS][BANKS][TAPS];

    logic signed [PROD_W-1:0]   mac_a, mac_b, prod;
    logic signed [ACC_W-1:0]    acc_sum, acc_shr;
    logic [DATA_W-1:0]          mac_res;
    logic                       mac_sat;

    // Shared MAC datapath; coefficients are unsigned, hence the zero-extension before the signed multiply.
    always_comb begin
        mac_a   = PROD_W'(delay_q[ch_q][tap_q]);
        mac_b   = PROD_W'($signed({1'b0, coeff_q[ch_q][bank_lat_q[ch_q]][tap_q]}));
        prod    = mac_a * mac_b;
        acc_sum = acc_q + ACC_W'(prod);
        acc_shr = acc_sum >>> COEFF_W;
        mac_sat = 1'b0;
        mac_res = acc_shr[DATA_W-1:0];
        if (acc_shr > RES_MAX) begin
            mac_res = RES_MAX[DATA_W-1:0];
            mac_sat = 1'b1;
        end else if (acc_shr < RES_MIN) begin
            mac_res = RES_MIN[DATA_W-1:0];
            mac_sat = 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        filter_data_d = filter_data_q;
        sat_flag_d    = sat_flag_q;
        sample_d      = sample_q;
        acc_d         = acc_q;
        ch_d          = ch_q;
        tap_d         = tap_q;
        bank_lat_d    = bank_lat_q;
        shadow_d      = shadow_q;
        shadow_sat_d  = shadow_sat_q;
        delay_d       = delay_q;
        coeff_d       = coeff_q;

        unique case (state_q)
            ST_IDLE: begin
                if (sample_valid) begin
                    sample_d = sample_in;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    for (int t = TAPS - 1; t > 0; t--) delay_d[c][t] = delay_q[c][t-1];
                    delay_d[c][0] = sample_q[c*DATA_W +: DATA_W];
                    bank_lat_d[c] = bank_sel[c*BANK_W +: BANK_W];
                end
                acc_d   = '0;
                ch_d    = '0;
                tap_d   = '0;
                state_d = ST_MAC;
            end
            ST_MAC: begin
                if (tap_q == TAP_W'(TAPS - 1)) begin
                    shadow_d[ch_q]     = mac_res;
                    shadow_sat_d[ch_q] = mac_sat;
                    acc_d              = '0;
                    tap_d              = '0;
                    if (ch_q == CH_W'(CHANNELS - 1)) begin
                        // Outputs load on entry to DONE so they are visible during the out_valid cycle.
                        for (int c = 0; c < CHANNELS; c++) filter_data_d[c*DATA_W +: DATA_W] = shadow_d[c];
                        sat_flag_d = shadow_sat_d;
                        state_d    = ST_DONE;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end else begin
                    acc_d = acc_sum;
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Coefficient writes are honoured in any state; a MAC reading the same entry this cycle sees the old value.
        if (update_en && (update_channel < UCH_W'(CHANNELS)))
            coeff_d[update_channel[CH_W-1:0]][update_bank][update_index] = update_value;

        busy_d      = (state_d != ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        overrun_d   = sample_valid && (state_q != ST_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
            filter_data_q <= '0;
            sat_flag_q    <= '0;
            sample_q      <= '0;
            acc_q         <= '0;
            ch_q          <= '0;
            tap_q         <= '0;
            shadow_sat_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                bank_lat_q[c] <= '0;
                shadow_q[c]   <= '0;
                for (int t = 0; t < TAPS; t++) delay_q[c][t] <= '0;
                // NOTE: the coefficient store is reset because its power-up contents define the default filters.
                for (int b = 0; b < BANKS; b++)
                    for (int t = 0; t < TAPS; t++) coeff_q[c][b][t] <= coeff_reset(b, t);
            end
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            overrun_q     <= overrun_d;
            filter_data_q <= filter_data_d;
            sat_flag_q    <= sat_flag_d;
            sample_q      <= sample_d;
            acc_q         <= acc_d;
            ch_q          <= ch_d;
            tap_q         <= tap_d;
            bank_lat_q    <= bank_lat_d;
            shadow_q      <= shadow_d;
            shadow_sat_q  <= shadow_sat_d;
            delay_q       <= delay_d;
            coeff_q       <= coeff_d;
        end
    end

    assign busy        = busy_q;
    assign out_valid   = out_valid_q;
    assign overrun     = overrun_q;
    assign filter_data = filter_data_q;
    assign sat_flag    = sat_flag_q;

endmodule

// File: tb/tb_fir_multichannel_engine.sv
// Scoreboard bench for fir_multichannel_engine: a behavioural filter model predicts each pass,
// and a monitor pops the prediction when out_valid fires.
module tb_fir_multichannel_engine;

    localparam int CHANNELS = 3;
    localparam int TAPS     = 16;
    localparam int DATA_W   = 16;
    localparam int COEFF_W  = 16;
    localparam int BANKS    = 4;
    localparam int LAT      = CHANNELS * TAPS + 2;

    logic                        sys_clk;
    logic                        rst_n;
    logic                        sample_valid;
    logic [CHANNELS*DATA_W-1:0]  sample_in;
    logic [CHANNELS*2-1:0]       bank_sel;
    logic                        busy;
    logic                        out_valid;
    logic [CHANNELS*DATA_W-1:0]  filter_data;
    logic [CHANNELS-1:0]         sat_flag;
    logic                        overrun;
    logic                        update_en;
    logic [2:0]                  update_channel;
    logic [1:0]                  update_bank;
    logic [3:0]                  update_index;
    logic [COEFF_W-1:0]          update_value;

    fir_multichannel_engine #(
        .CHANNELS(CHANNELS), .TAPS(TAPS), .DATA_W(DATA_W), .COEFF_W(COEFF_W), .BANKS(BANKS)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_in(sample_in),
        .bank_sel(bank_sel), .busy(busy), .out_valid(out_valid), .filter_data(filter_data),
        .sat_flag(sat_flag), .overrun(overrun), .update_en(update_en),
        .update_channel(update_channel), .update_bank(update_bank),
        .update_index(update_index), .update_value(update_value)
    );

    typedef struct {
        logic [CHANNELS*DATA_W-1:0] data;
        logic [CHANNELS-1:0]        sat;
        int                         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ov_count = 0;
    int   ov0;

    int delay_m [CHANNELS][TAPS];
    int coeff_m [CHANNELS][BANKS][TAPS];
    int bank_m  [CHANNELS];

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < CHANNELS; c++)
            for (int t = 0; t < TAPS; t++) begin
                delay_m[c][t] = 0;
                for (int b = 0; b < BANKS; b++) coeff_m[c][b][t] = 0;
                coeff_m[c][0][t] = (t == 0) ? 65535 : 0;
                coeff_m[c][1][t] = 65536 / TAPS;
            end
    endfunction

    task automatic set_banks(input int b0, input int b1, input int b2);
        bank_sel  = {2'(b2), 2'(b1), 2'(b0)};
        bank_m[0] = b0;
        bank_m[1] = b1;
        bank_m[2] = b2;
    endtask

    task automatic write_coef(input int ch, input int bank, input int idx, input int val);
        update_channel = 3'(ch);
        update_bank    = 2'(bank);
        update_index   = 4'(idx);
        update_value   = 16'(val);
        update_en      = 1'b1;
        @(posedge sys_clk); #1;
        update_en = 1'b0;
        if (ch < CHANNELS) coeff_m[ch][bank][idx] = val;
    endtask

    task automatic send(input int s0, input int s1, input int s2);
        exp_t   e;
        int     s [CHANNELS];
        longint acc;
        longint res;
        s = '{s0, s1, s2};
        for (int c = 0; c < CHANNELS; c++) begin
            for (int t = TAPS - 1; t > 0; t--) delay_m[c][t] = delay_m[c][t-1];
            delay_m[c][0] = s[c];
            acc = 0;
            for (int t = 0; t < TAPS; t++)
                acc += longint'(delay_m[c][t]) * longint'(coeff_m[c][bank_m[c]][t]);
            res = acc >>> COEFF_W;
            e.sat[c] = 1'b0;
            if (res > 32767)  begin res = 32767;  e.sat[c] = 1'b1; end
            if (res < -32768) begin res = -32768; e.sat[c] = 1'b1; end
            e.data[c*DATA_W +: DATA_W] = res[DATA_W-1:0];
        end
        e.cyc = cyc + LAT;
        sb_q.push_back(e);
        sample_in    = {16'(s2), 16'(s1), 16'(s0)};
        sample_valid = 1'b1;
        @(posedge sys_clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < 200) begin
            @(posedge sys_clk); #1;
            n++;
        end
        check({"drain_", tag}, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: every out_valid must match the oldest outstanding prediction, at the predicted cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (out_valid) begin
                ov_count++;
                if (sb_q.size() == 0) begin
                    check("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    for (int c = 0; c < CHANNELS; c++)
                        check($sformatf("data_ch%0d", c), 64'(filter_data[c*DATA_W +: DATA_W]),
                              64'(e.data[c*DATA_W +: DATA_W]));
                    check("sat_flag", 64'(sat_flag), 64'(e.sat));
                    check("latency", 64'(cyc), 64'(e.cyc));
                    check("busy_in_done", 64'(busy), 64'd1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cycles=%0d limit reached", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0; sample_valid = 1'b0; sample_in = '0; bank_sel = '0;
        update_en = 1'b0; update_channel = '0; update_bank = '0; update_index = '0; update_value = '0;
        model_reset();
        set_banks(0, 0, 0);
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_filter_data", 64'(filter_data), 64'd0);
        check("rst_sat_flag", 64'(sat_flag), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // 1) pass-through bank, 0xffff gain floors each sample
        send(100, -200, 32767);
        check("t1_busy_after_accept", 64'(busy), 64'd1);
        wait_idle("t1");
        check("t1_data", 64'(filter_data), 64'h7ffe_ff38_0063);

        // 2) moving-average bank from a clean delay line
        do_reset();
        @(posedge sys_clk); #1;
        set_banks(1, 1, 1);
        send(1000, 0, 0);
        wait_idle("t2_first");
        check("t2_first_ch0", 64'(filter_data[15:0]), 64'd62);
        for (int i = 1; i < TAPS; i++) begin
            send(1000, 0, 0);
            wait_idle("t2");
        end
        check("t2_full_ch0", 64'(filter_data[15:0]), 64'd1000);

        // 3) ch1 bank2 all 0xffff saturates, neighbours unaffected
        set_banks(0, 2, 1);
        for (int t = 0; t < TAPS; t++) write_coef(1, 2, t, 16'hffff);
        for (int i = 0; i < TAPS; i++) begin
            send(500, 30000, -7);
            wait_idle("t3");
        end
        check("t3_ch1_sat", 64'(filter_data[31:16]), 64'h7fff);
        check("t3_sat_flag", 64'(sat_flag), 64'b010);
        check("t3_ch0", 64'(filter_data[15:0]), 64'd499);

        // 4) sample during a pass is dropped with an overrun pulse
        set_banks(1, 1, 1);
        ov0 = ov_count;
        send(200, -300, 5);
        repeat (10) begin @(posedge sys_clk); #1; end
        sample_in    = 48'h270f_270f_270f;
        sample_valid = 1'b1;
        @(posedge sys_clk); #1;
        sample_valid = 1'b0;
        check("t4_overrun_hi", 64'(overrun), 64'd1);
        @(posedge sys_clk); #1;
        check("t4_overrun_lo", 64'(overrun), 64'd0);
        wait_idle("t4");
        repeat (60) @(posedge sys_clk);
        #1;
        check("t4_single_out_valid", 64'(ov_count - ov0), 64'd1);
        send(7, 7, 7);
        wait_idle("t4_next");

        // 5) reset in the middle of MAC aborts the pass
        set_banks(0, 0, 0);
        ov0 = ov_count;
        send(-5000, 42, 32767);
        repeat (21) begin @(posedge sys_clk); #1; end
        rst_n = 1'b0;
        #1;
        check("t5_filter_data", 64'(filter_data), 64'd0);
        check("t5_sat_flag", 64'(sat_flag), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        sb_q.delete();
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1 rst_n = 1'b1;
        repeat (60) @(posedge sys_clk);
        #1;
        check("t5_no_out_valid", 64'(ov_count - ov0), 64'd0);
        send(1234, -1, -32768);
        wait_idle("t5");
        check("t5_after_reset", 64'(filter_data), 64'h8000_ffff_04d1);

        // 6) out-of-range channel writes are ignored; an in-range write takes effect
        write_coef(3, 0, 0, 0);
        write_coef(3, 0, 1, 16'h1234);
        send(300, 300, 300);
        wait_idle("t6");
        check("t6_ignored", 64'(filter_data), 64'h012b_012b_012b);
        write_coef(2, 0, 1, 16'h8000);
        send(300, 300, 300);
        wait_idle("t6_write");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
